ex_stage: RTL and testbench

Execute stage of the 5-stage RISC-V pipeline, directly downstream of ID_stage.
- Holds the ID/EX pipeline register and applies hazard-unit forwarding to both operands.
- Computes the ALU result, resolves branches and jumps, and produces PCSrcE/PCTargetE for the fetch stage.
- Its outputs feed the EX/MEM register and the hazard unit.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/ex_stage_alu.sv | 34 +++
 rtl/ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RISC-V pipeline execute stage.
//   - ALU operation codes (ALU_ADD .. ALU_SLT)
//   - Forwarding select codes (FWD_REG, FWD_WB, FWD_MEM)
//   - ResultSrc codes (RES_ALU, RES_MEM, RES_PC4)
//   - Branch funct3 codes (F3_BEQ .. F3_BGEU)
// Optional build macro referenced by users of this package: EX_BRANCH_EXT_EN.
package riscv_pkg;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Operand forwarding select; 2'b11 falls back to register data
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Writeback result select, passed through this stage
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Branch condition encodings (instr[14:12])
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_stage_alu.sv
// alu: purely combinational integer ALU.
// Ports:
//   SrcA, SrcB  in  WIDTH  operands
//   ALUControl  in  3      operation (riscv_pkg ALU_* codes; 110/111 give 0)
//   Result      out WIDTH  result, add/sub wrap modulo 2^WIDTH
//   Zero        out 1      Result == 0
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic             Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_XOR: Result = SrcA ^ SrcB;
            ALU_SLT: Result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RISC-V pipeline.
// Holds the ID/EX register, applies operand forwarding, runs the ALU and
// resolves branches/jumps into PCSrcE/PCTargetE.
// Ports:
//   clk, reset (async, active-high), FlushE (sync bubble insert)
//   *D inputs       ID-stage values captured into the ID/EX register
//   ForwardAE/BE    operand select (00 reg, 01 ResultW, 10 ALUResultM, 11 reg)
//   ALUResultM, ResultW  forwarded values from MEM / WB
//   ALUResultE, ZeroE, WriteDataE, PCTargetE, PCSrcE  combinational EX results
//   PCplus4E, rs1E, rs2E, rdE, ResultSrcE, RegWriteE, MemWriteE  registered
// Build macro: EX_BRANCH_EXT_EN -- when defined, funct3 selects the branch
// condition (beq/bne/blt/bge/bltu/bgeu); otherwise every branch is beq.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  FlushE,
    input  logic [XLEN-1:0]       RD1D,
    input  logic [XLEN-1:0]       RD2D,
    input  logic [XLEN-1:0]       PCD,
    input  logic [XLEN-1:0]       PCplus4D,
    input  logic [XLEN-1:0]       ImmExtD,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rdD,
    input  logic [2:0]            funct3D,
    input  logic [1:0]            ResultSrcD,
    input  logic [2:0]            ALUControlD,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic                  ALUSrcD,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [XLEN-1:0]       ALUResultM,
    input  logic [XLEN-1:0]       ResultW,
    output logic [XLEN-1:0]       ALUResultE,
    output logic [XLEN-1:0]       WriteDataE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic [XLEN-1:0]       PCplus4E,
    output logic [REG_ADDR_W-1:0] rs1E,
    output logic [REG_ADDR_W-1:0] rs2E,
    output logic [REG_ADDR_W-1:0] rdE,
    output logic [1:0]            ResultSrcE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  PCSrcE,
    output logic                  ZeroE
);

    // ID/EX pipeline register
    logic [XLEN-1:0]       rd1_q, rd2_q, pc_q, pcplus4_q, imm_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [1:0]            resultsrc_q;
    logic [2:0]            alucontrol_q;
    logic                  regwrite_q, memwrite_q, branch_q, jump_q, alusrc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_q        <= '0;
            rd2_q        <= '0;
            pc_q         <= '0;
            pcplus4_q    <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            resultsrc_q  <= '0;
            alucontrol_q <= '0;
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            alusrc_q     <= 1'b0;
        end else if (FlushE) begin
            // Bubble: an all-zero entry is a NOP with no side effects
            rd1_q        <= '0;
            rd2_q        <= '0;
            pc_q         <= '0;
            pcplus4_q    <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            resultsrc_q  <= '0;
            alucontrol_q <= '0;
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            alusrc_q     <= 1'b0;
        end else begin
            rd1_q        <= RD1D;
            rd2_q        <= RD2D;
            pc_q         <= PCD;
            pcplus4_q    <= PCplus4D;
            imm_q        <= ImmExtD;
            rs1_q        <= rs1D;
            rs2_q        <= rs2D;
            rd_q         <= rdD;
            resultsrc_q  <= ResultSrcD;
            alucontrol_q <= ALUControlD;
            regwrite_q   <= RegWriteD;
            memwrite_q   <= MemWriteD;
            branch_q     <= BranchD;
            jump_q       <= JumpD;
            alusrc_q     <= ALUSrcD;
        end
    end

    // Forwarding muxes; code 11 falls back to register data
    logic [XLEN-1:0] src_a, fwd_b, src_b;

    always_comb begin
        src_a = rd1_q;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = rd1_q;
        endcase
    end

    always_comb begin
        fwd_b = rd2_q;
        case (ForwardBE)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALUResultM;
            default: fwd_b = rd2_q;
        endcase
    end

    assign src_b = alusrc_q ? imm_q : fwd_b;

    alu #(
        .WIDTH(XLEN)
    ) u_alu (
        .SrcA      (src_a),
        .SrcB      (src_b),
        .ALUControl(alucontrol_q),
        .Result    (ALUResultE),
        .Zero      (ZeroE)
    );

    // Branch condition
    logic taken;

`ifdef EX_BRANCH_EXT_EN
    logic [2:0] funct3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_q <= '0;
        end else if (FlushE) begin
            funct3_q <= '0;
        end else begin
            funct3_q <= funct3D;
        end
    end

    // Compares use the operands directly so the ALU op does not matter
    logic lt_s, lt_u, eq;
    assign lt_s = $signed(src_a) < $signed(src_b);
    assign lt_u = src_a < src_b;
    assign eq   = (src_a == src_b);

    always_comb begin
        taken = 1'b0;
        case (funct3_q)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_funct3;
    assign unused_funct3 = ^funct3D;
    assign taken = ZeroE;
`endif

    assign PCSrcE     = (branch_q & taken) | jump_q;
    assign PCTargetE  = pc_q + imm_q;
    assign WriteDataE = fwd_b;
    assign PCplus4E   = pcplus4_q;
    assign rs1E       = rs1_q;
    assign rs2E       = rs2_q;
    assign rdE        = rd_q;
    assign ResultSrcE = resultsrc_q;
    assign RegWriteE  = regwrite_q;
    assign MemWriteE  = memwrite_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;

    logic        clk, reset, FlushE;
    logic [31:0] RD1D, RD2D, PCD, PCplus4D, ImmExtD;
    logic [4:0]  rs1D, rs2D, rdD;
    logic [2:0]  funct3D;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic        RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultM, ResultW;
    logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCplus4E;
    logic [4:0]  rs1E, rs2E, rdE;
    logic [1:0]  ResultSrcE;
    logic        RegWriteE, MemWriteE, PCSrcE, ZeroE;

    int vectors = 0;
    int miscompares = 0;

    ex_stage #(
        .XLEN      (32),
        .REG_ADDR_W(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .FlushE     (FlushE),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .PCD        (PCD),
        .PCplus4D   (PCplus4D),
        .ImmExtD    (ImmExtD),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rdD        (rdD),
        .funct3D    (funct3D),
        .ResultSrcD (ResultSrcD),
        .ALUControlD(ALUControlD),
        .RegWriteD  (RegWriteD),
        .MemWriteD  (MemWriteD),
        .BranchD    (BranchD),
        .JumpD      (JumpD),
        .ALUSrcD    (ALUSrcD),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ALUResultM (ALUResultM),
        .ResultW    (ResultW),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .PCTargetE  (PCTargetE),
        .PCplus4E   (PCplus4E),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .ResultSrcE (ResultSrcE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .PCSrcE     (PCSrcE),
        .ZeroE      (ZeroE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        FlushE = 0; RD1D = 0; RD2D = 0; PCD = 0; PCplus4D = 0; ImmExtD = 0;
        rs1D = 0; rs2D = 0; rdD = 0; funct3D = 0; ResultSrcD = 0; ALUControlD = 0;
        RegWriteD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0; ALUSrcD = 0;
        ForwardAE = 0; ForwardBE = 0; ALUResultM = 0; ResultW = 0;
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #12;
        vectors++; if (ALUResultE !== 32'h0) begin miscompares++; $display("FAIL rst_alu got=%h exp=%h", ALUResultE, 32'h0); end
        vectors++; if (ZeroE !== 1'b1) begin miscompares++; $display("FAIL rst_zero got=%b exp=1", ZeroE); end
        vectors++; if (PCTargetE !== 32'h0) begin miscompares++; $display("FAIL rst_target got=%h exp=0", PCTargetE); end
        vectors++; if (PCSrcE !== 1'b0) begin miscompares++; $display("FAIL rst_pcsrc got=%b exp=0", PCSrcE); end
        vectors++; if (WriteDataE !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got=%h exp=0", WriteDataE); end
        vectors++; if ({RegWriteE, MemWriteE, rdE, PCplus4E} !== 39'h0) begin miscompares++; $display("FAIL rst_regs got=%b/%b/%h/%h exp=0", RegWriteE, MemWriteE, rdE, PCplus4E); end
        @(negedge clk);
        reset = 1'b0;
        // Load a writing instruction, then reset mid-cycle
        RegWriteD = 1; rdD = 5'd5; RD1D = 32'd3; RD2D = 32'd1; ALUControlD = 3'b000;
        step();
        vectors++; if (RegWriteE !== 1'b1 || rdE !== 5'd5) begin miscompares++; $display("FAIL load_pre got=%b/%0d exp=1/5", RegWriteE, rdE); end
        vectors++; if (ALUResultE !== 32'd4) begin miscompares++; $display("FAIL load_alu got=%0d exp=4", ALUResultE); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (RegWriteE !== 1'b0 || rdE !== 5'd0) begin miscompares++; $display("FAIL async_rst got=%b/%0d exp=0/0", RegWriteE, rdE); end
        vectors++; if (ALUResultE !== 32'h0 || ZeroE !== 1'b1) begin miscompares++; $display("FAIL async_rst_alu got=%h/%b exp=0/1", ALUResultE, ZeroE); end
        // Reset must also beat FlushE and an active edge
        FlushE = 1;
        step();
        vectors++; if (RegWriteE !== 1'b0 || rdE !== 5'd0) begin miscompares++; $display("FAIL rst_hold got=%b/%0d exp=0/0", RegWriteE, rdE); end
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_alu();
        clear_inputs();
        RD1D = 32'd7; RD2D = 32'd5; ALUControlD = 3'b001;
        step();
        vectors++; if (ALUResultE !== 32'd2) begin miscompares++; $display("FAIL alu_sub got=%h exp=%h", ALUResultE, 32'd2); end
        vectors++; if (WriteDataE !== 32'd5) begin miscompares++; $display("FAIL alu_wdata got=%h exp=%h", WriteDataE, 32'd5); end
        vectors++; if (ZeroE !== 1'b0) begin miscompares++; $display("FAIL alu_zero got=%b exp=0", ZeroE); end
        RD1D = 32'hFFFF_FFFF; RD2D = 32'd1; ALUControlD = 3'b101;
        step();
        vectors++; if (ALUResultE !== 32'd1) begin miscompares++; $display("FAIL alu_slt got=%h exp=1", ALUResultE); end
        RD1D = 32'd1; RD2D = 32'hFFFF_FFFF; ALUControlD = 3'b101;
        step();
        vectors++; if (ALUResultE !== 32'd0) begin miscompares++; $display("FAIL alu_slt_neg got=%h exp=0", ALUResultE); end
        RD1D = 32'h0000_F0F0; RD2D = 32'h0000_0FF0; ALUControlD = 3'b010;
        step();
        vectors++; if (ALUResultE !== 32'h0000_00F0) begin miscompares++; $display("FAIL alu_and got=%h exp=000000f0", ALUResultE); end
        ALUControlD = 3'b011;
        step();
        vectors++; if (ALUResultE !== 32'h0000_FFF0) begin miscompares++; $display("FAIL alu_or got=%h exp=0000fff0", ALUResultE); end
        ALUControlD = 3'b100;
        step();
        vectors++; if (ALUResultE !== 32'h0000_FF00) begin miscompares++; $display("FAIL alu_xor got=%h exp=0000ff00", ALUResultE); end
        ALUControlD = 3'b110;
        step();
        vectors++; if (ALUResultE !== 32'h0 || ZeroE !== 1'b1) begin miscompares++; $display("FAIL alu_110 got=%h/%b exp=0/1", ALUResultE, ZeroE); end
        ALUControlD = 3'b111;
        step();
        vectors++; if (ALUResultE !== 32'h0) begin miscompares++; $display("FAIL alu_111 got=%h exp=0", ALUResultE); end
        RD1D = 32'hFFFF_FFFF; RD2D = 32'd1; ALUControlD = 3'b000;
        step();
        vectors++; if (ALUResultE !== 32'h0 || ZeroE !== 1'b1) begin miscompares++; $display("FAIL alu_wrap got=%h/%b exp=0/1", ALUResultE, ZeroE); end
    endtask

    task automatic test_forward();
        clear_inputs();
        RD1D = 32'd1; RD2D = 32'd77; ImmExtD = 32'd4; ALUSrcD = 1; ALUControlD = 3'b000;
        rs1D = 5'd3; rs2D = 5'd4; ResultSrcD = 2'b10; PCplus4D = 32'h104;
        ForwardAE = 2'b10; ALUResultM = 32'd100; ResultW = 32'd20;
        step();
        vectors++; if (ALUResultE !== 32'd104) begin miscompares++; $display("FAIL fwd_mem got=%0d exp=104", ALUResultE); end
        vectors++; if (rs1E !== 5'd3 || rs2E !== 5'd4 || ResultSrcE !== 2'b10 || PCplus4E !== 32'h104) begin
            miscompares++; $display("FAIL pass_thru got=%0d/%0d/%b/%h exp=3/4/10/104", rs1E, rs2E, ResultSrcE, PCplus4E);
        end
        ForwardAE = 2'b01;
        #1;
        vectors++; if (ALUResultE !== 32'd24) begin miscompares++; $display("FAIL fwd_wb got=%0d exp=24", ALUResultE); end
        ForwardAE = 2'b11;
        #1;
        vectors++; if (ALUResultE !== 32'd5) begin miscompares++; $display("FAIL fwd_11 got=%0d exp=5", ALUResultE); end
        ForwardBE = 2'b10;
        #1;
        vectors++; if (WriteDataE !== 32'd100) begin miscompares++; $display("FAIL fwdb_mem got=%0d exp=100", WriteDataE); end
        // ALUSrc selects the immediate, so B forwarding must not reach the ALU
        vectors++; if (ALUResultE !== 32'd5) begin miscompares++; $display("FAIL fwdb_imm got=%0d exp=5", ALUResultE); end
        ForwardBE = 2'b01;
        #1;
        vectors++; if (WriteDataE !== 32'd20) begin miscompares++; $display("FAIL fwdb_wb got=%0d exp=20", WriteDataE); end
        ForwardBE = 2'b11;
        #1;
        vectors++; if (WriteDataE !== 32'd77) begin miscompares++; $display("FAIL fwdb_11 got=%0d exp=77", WriteDataE); end
    endtask

    task automatic test_branch();
        clear_inputs();
        BranchD = 1; RD1D = 32'd9; RD2D = 32'd9; ALUControlD = 3'b001;
        PCD = 32'h0040_0000; ImmExtD = 32'h0000_0010; funct3D = 3'b000;
        step();
        vectors++; if (PCSrcE !== 1'b1) begin miscompares++; $display("FAIL br_taken got=%b exp=1", PCSrcE); end
        vectors++; if (PCTargetE !== 32'h0040_0010) begin miscompares++; $display("FAIL br_target got=%h exp=00400010", PCTargetE); end
        RD2D = 32'd8;
        step();
        vectors++; if (PCSrcE !== 1'b0) begin miscompares++; $display("FAIL br_not got=%b exp=0", PCSrcE); end
        BranchD = 0; JumpD = 1;
        step();
        vectors++; if (PCSrcE !== 1'b1) begin miscompares++; $display("FAIL jump got=%b exp=1", PCSrcE); end
        JumpD = 0; PCD = 32'hFFFF_FFF0; ImmExtD = 32'h0000_0020;
        step();
        vectors++; if (PCTargetE !== 32'h0000_0010) begin miscompares++; $display("FAIL target_wrap got=%h exp=00000010", PCTargetE); end
    endtask

    task automatic test_flush();
        clear_inputs();
        MemWriteD = 1; BranchD = 1; RD1D = 32'd4; RD2D = 32'd4; ALUControlD = 3'b001; rdD = 5'd7;
        FlushE = 1;
        step();
        vectors++; if (MemWriteE !== 1'b0 || PCSrcE !== 1'b0 || rdE !== 5'd0) begin
            miscompares++; $display("FAIL flush got=%b/%b/%0d exp=0/0/0", MemWriteE, PCSrcE, rdE);
        end
        // Taken branch in EX: redirect holds this cycle even with FlushE
        FlushE = 0;
        step();
        vectors++; if (PCSrcE !== 1'b1 || MemWriteE !== 1'b1 || rdE !== 5'd7) begin
            miscompares++; $display("FAIL flush_load got=%b/%b/%0d exp=1/1/7", PCSrcE, MemWriteE, rdE);
        end
        FlushE = 1;
        #1;
        vectors++; if (PCSrcE !== 1'b1) begin miscompares++; $display("FAIL flush_same got=%b exp=1", PCSrcE); end
        step();
        vectors++; if (PCSrcE !== 1'b0 || MemWriteE !== 1'b0) begin miscompares++; $display("FAIL flush_next got=%b/%b exp=0/0", PCSrcE, MemWriteE); end
        FlushE = 0;
    endtask

    task automatic test_branch_ext();
        logic exp_blt, exp_bltu, exp_bne, exp_bgeu;
`ifdef EX_BRANCH_EXT_EN
        exp_blt = 1'b1; exp_bltu = 1'b0; exp_bne = 1'b1; exp_bgeu = 1'b1;
`else
        // Every branch is beq here, and these operands differ
        exp_blt = 1'b0; exp_bltu = 1'b0; exp_bne = 1'b0; exp_bgeu = 1'b0;
`endif
        clear_inputs();
        BranchD = 1; ALUControlD = 3'b001; RD1D = 32'hFFFF_FFFE; RD2D = 32'd1;
        funct3D = 3'b100;
        step();
        vectors++; if (PCSrcE !== exp_blt) begin miscompares++; $display("FAIL ext_blt got=%b exp=%b", PCSrcE, exp_blt); end
        funct3D = 3'b110;
        step();
        vectors++; if (PCSrcE !== exp_bltu) begin miscompares++; $display("FAIL ext_bltu got=%b exp=%b", PCSrcE, exp_bltu); end
        funct3D = 3'b001;
        step();
        vectors++; if (PCSrcE !== exp_bne) begin miscompares++; $display("FAIL ext_bne got=%b exp=%b", PCSrcE, exp_bne); end
        funct3D = 3'b111;
        step();
        vectors++; if (PCSrcE !== exp_bgeu) begin miscompares++; $display("FAIL ext_bgeu got=%b exp=%b", PCSrcE, exp_bgeu); end
        // Equal operands: beq taken in both builds
        funct3D = 3'b000; RD2D = 32'hFFFF_FFFE;
        step();
        vectors++; if (PCSrcE !== 1'b1) begin miscompares++; $display("FAIL ext_beq got=%b exp=1", PCSrcE); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_forward();
        test_branch();
        test_flush();
        test_branch_ext();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
